// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID/EX/MEM hazard sources in,
// pipeline enables/flushes and performance counts out.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       id_rs1, id_rs2;
  logic             id_uses_rs1, id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             dmem_req, dmem_ready;
  logic             pc_write, ifIdWrite;
  logic             IFflush, idExFlush;
  logic             memStall;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rd, ex_mem_read, ex_redirect, dmem_req, dmem_ready,
    output pc_write, ifIdWrite, IFflush, idExFlush, memStall,
           stall_cnt, flush_cnt
  );

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rd, ex_mem_read, ex_redirect, dmem_req, dmem_ready,
    input  pc_write, ifIdWrite, IFflush, idExFlush, memStall,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, redirect flush, load-use bubble.
// Define HAZARD_CTRL_PERF_EN to build the saturating stall/flush counters.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic         clk,
  input  logic         resetn,
  hazard_ctrl_if.slave bus
);
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;
  localparam logic [1:0] FC_LOAD  = 2'(FLUSH_CYCLES - 1);

  logic [1:0] r_state, w_state_nxt;
  logic [1:0] r_fcnt, w_fcnt_nxt;
  logic       w_memwait, w_loaduse, w_redir_acc;
  logic       w_pw, w_ifw, w_iff, w_idf, w_ms;

  assign w_memwait = bus.dmem_req & ~bus.dmem_ready;
  assign w_loaduse = bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                     ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                      (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    w_pw        = 1'b1;
    w_ifw       = 1'b1;
    w_iff       = 1'b0;
    w_idf       = 1'b0;
    w_ms        = 1'b0;
    w_state_nxt = RUN;
    w_fcnt_nxt  = r_fcnt;
    w_redir_acc = 1'b0;
    if (w_memwait) begin
      // Freeze everything; a redirect held in EX is picked up on release.
      w_pw        = 1'b0;
      w_ifw       = 1'b0;
      w_ms        = 1'b1;
      w_state_nxt = MEM_WAIT;
    end else if (r_state == FLUSH) begin
      w_iff       = 1'b1;
      w_idf       = 1'b1;
      w_fcnt_nxt  = r_fcnt - 2'd1;
      w_state_nxt = (r_fcnt <= 2'd1) ? RUN : FLUSH;
    end else if (bus.ex_redirect) begin
      // RUN, or MEM_WAIT releasing this cycle: both follow RUN priorities.
      w_iff       = 1'b1;
      w_idf       = 1'b1;
      w_redir_acc = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = FLUSH;
        w_fcnt_nxt  = FC_LOAD;
      end
    end else if (w_loaduse) begin
      w_pw  = 1'b0;
      w_ifw = 1'b0;
      w_idf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= RUN;
      r_fcnt  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Reset forces the flush/hold pattern straight through to the pipeline.
  assign bus.pc_write  = resetn & w_pw;
  assign bus.ifIdWrite = resetn & w_ifw;
  assign bus.IFflush   = ~resetn | w_iff;
  assign bus.idExFlush = ~resetn | w_idf;
  assign bus.memStall  = resetn & w_ms;

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pw && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redir_acc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_redir_acc;
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: FLUSH_CYCLES=3 and =1 instances share stimulus.
module tb_hazard_ctrl;
  localparam int CNT_W = 32;
`ifdef HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, ifIdWrite, IFflush, idExFlush, memStall}
  localparam logic [4:0] NORM   = 5'b11000;
  localparam logic [4:0] STALL  = 5'b00001;
  localparam logic [4:0] FLSH   = 5'b11110;
  localparam logic [4:0] BUBBLE = 5'b00010;
  localparam logic [4:0] RST    = 5'b00110;

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, redir, req, rdy, rstn;
  } in_t;

  typedef struct packed {
    logic [4:0] e3, e1;
    logic       acc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  in_t  cur = '0;
  exp_t sb[$];
  int   tests = 0, fails = 0;
  logic [CNT_W-1:0] exp_stall = '0, exp_flush = '0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bi3();
  hazard_ctrl_if #(.CNT_W(CNT_W)) bi1();

  assign bi3.id_rs1 = cur.rs1;      assign bi1.id_rs1 = cur.rs1;
  assign bi3.id_rs2 = cur.rs2;      assign bi1.id_rs2 = cur.rs2;
  assign bi3.id_uses_rs1 = cur.u1;  assign bi1.id_uses_rs1 = cur.u1;
  assign bi3.id_uses_rs2 = cur.u2;  assign bi1.id_uses_rs2 = cur.u2;
  assign bi3.ex_rd = cur.rd;        assign bi1.ex_rd = cur.rd;
  assign bi3.ex_mem_read = cur.mr;  assign bi1.ex_mem_read = cur.mr;
  assign bi3.ex_redirect = cur.redir; assign bi1.ex_redirect = cur.redir;
  assign bi3.dmem_req = cur.req;    assign bi1.dmem_req = cur.req;
  assign bi3.dmem_ready = cur.rdy;  assign bi1.dmem_ready = cur.rdy;

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CNT_W)) u3 (.clk(clk), .resetn(resetn), .bus(bi3.slave));
  hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(CNT_W)) u1 (.clk(clk), .resetn(resetn), .bus(bi1.slave));

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1,
                             input bit u2, input logic [4:0] rd, input bit mr, input bit redir,
                             input bit req, input bit rdy, input bit rstn);
    in_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.redir = redir; v.req = req; v.rdy = rdy; v.rstn = rstn;
    return v;
  endfunction

  task automatic step(input string tag, input in_t v, input logic [4:0] e3,
                      input logic [4:0] e1, input bit acc);
    exp_t e;
    logic [4:0] o3, o1;
    @(negedge clk);
    cur    = v;
    resetn = v.rstn;
    sb.push_back('{e3: e3, e1: e1, acc: acc});
    if (!v.rstn) begin
      exp_stall = '0;
      exp_flush = '0;
    end
    #2;
    e  = sb.pop_front();
    o3 = {bi3.pc_write, bi3.ifIdWrite, bi3.IFflush, bi3.idExFlush, bi3.memStall};
    o1 = {bi1.pc_write, bi1.ifIdWrite, bi1.IFflush, bi1.idExFlush, bi1.memStall};
    tests++;
    assert (o3 === e.e3) else begin
      fails++; $error("FAIL %s fc3 outs got %b want %b", tag, o3, e.e3);
    end
    tests++;
    assert (o1 === e.e1) else begin
      fails++; $error("FAIL %s fc1 outs got %b want %b", tag, o1, e.e1);
    end
    tests++;
    assert (bi3.stall_cnt === exp_stall) else begin
      fails++; $error("FAIL %s stall_cnt got %0d want %0d", tag, bi3.stall_cnt, exp_stall);
    end
    tests++;
    assert (bi3.flush_cnt === exp_flush) else begin
      fails++; $error("FAIL %s flush_cnt got %0d want %0d", tag, bi3.flush_cnt, exp_flush);
    end
    if (PERF && v.rstn) begin
      if (!e.e3[4]) exp_stall = exp_stall + 1'b1;
      if (e.acc)    exp_flush = exp_flush + 1'b1;
    end
  endtask

  initial begin
    in_t q, lu;
    q  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    lu = mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 1);

    step("rst_busy",  mk(5, 0, 1, 0, 5, 1, 1, 1, 0, 0), RST, RST, 0);
    step("rst_hold",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RST, RST, 0);
    step("first_run", q, NORM, NORM, 0);

    step("lu_rs1",    lu, BUBBLE, BUBBLE, 0);
    step("lu_after",  mk(5, 0, 1, 0, 0, 0, 0, 0, 0, 1), NORM, NORM, 0);
    step("lu_rs2",    mk(0, 7, 0, 1, 7, 1, 0, 0, 0, 1), BUBBLE, BUBBLE, 0);
    step("x0_exempt", mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 1), NORM, NORM, 0);
    step("no_use",    mk(5, 0, 0, 0, 5, 1, 0, 0, 0, 1), NORM, NORM, 0);

    for (int i = 0; i < 3; i++)
      step("memwait", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), STALL, STALL, 0);
    step("mem_rel",   mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), NORM, NORM, 0);
    step("post_mem",  q, NORM, NORM, 0);

    step("redir",     mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1), FLSH, FLSH, 1);
    step("flush2",    q, FLSH, NORM, 0);
    step("flush3_lu", lu, FLSH, BUBBLE, 0);
    step("flush_end", q, NORM, NORM, 0);

    step("rdmw1",     mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1), STALL, STALL, 0);
    step("rdmw2",     mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1), STALL, STALL, 0);
    step("rdmw_rel",  mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1), FLSH, FLSH, 1);
    step("rdmw_f2",   q, FLSH, NORM, 0);
    step("rdmw_f3",   q, FLSH, NORM, 0);
    step("rdmw_end",  q, NORM, NORM, 0);

    step("redir_b",   mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1), FLSH, FLSH, 1);
    step("flush_c1",  q, FLSH, NORM, 0);
    step("rst_flush", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RST, RST, 0);
    step("rst_rel",   q, NORM, NORM, 0);
    step("rst_rel2",  q, NORM, NORM, 0);

    step("redir_c",   mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1), FLSH, FLSH, 1);
    step("flush_mw",  mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), STALL, STALL, 0);
    step("mw_to_run", q, NORM, NORM, 0);
    step("final",     q, NORM, NORM, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
